udp_rx_pkt_buffer: RTL and testbench



---
 rtl/udp_rx_pkt_buffer_if.sv | 34 +++
 rtl/udp_rx_pkt_buffer.sv | 248 ++++++++++++++++++++++++
 tb/tb_udp_rx_pkt_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_pkt_buffer_if.sv
// udp_rx_pkt_buffer_if: receiver-side write signals and user-side read/status signals
// of the UDP receive packet buffer. master = receiver/user, slave = buffer.
interface udp_rx_pkt_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              in_eof;
    logic              in_good;
    logic [15:0]       in_length;

    logic              pkt_avail;
    logic [15:0]       pkt_length;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;

    logic [ADDR_W:0]   used_words;
    logic [15:0]       drop_cnt;
    logic              ovf;

    modport master (
        output in_valid, in_data, in_sof, in_eof, in_good, in_length, rd_req,
        input  pkt_avail, pkt_length, rd_data, rd_valid, rd_last, used_words, drop_cnt, ovf
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_eof, in_good, in_length, rd_req,
        output pkt_avail, pkt_length, rd_data, rd_valid, rd_last, used_words, drop_cnt, ovf
    );
endinterface

// File: rtl/udp_rx_pkt_buffer.sv
// udp_rx_pkt_buffer: store-and-forward buffer holding several committed UDP payloads.
// Define UDP_RXBUF_STATS_EN to implement drop_cnt/ovf; otherwise both are tied to 0.
module udp_rx_pkt_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned PKT_W  = 2
) (
    input logic                clk,
    input logic                clr,
    udp_rx_pkt_buffer_if.slave bus
);
    localparam int unsigned DescW = 16 + ADDR_W;
    localparam int unsigned QptrW = PKT_W + 1;

    typedef enum logic [1:0] {StIdle, StFill, StSkip} wr_state_e;

    logic [DATA_W-1:0] mem      [2**ADDR_W];
    logic [DescW-1:0]  desc_mem [2**PKT_W];

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] cm_ptr_q, cm_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              bad_q, bad_d;
    logic [ADDR_W:0]   used_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              start, eof_now;
    logic              push, pop;
    logic              drop_abandon, drop_resolve;
    logic [DescW-1:0]  push_desc, head_desc;

    logic [QptrW-1:0]  dq_wr_q, dq_wr_d, dq_rd_q, dq_rd_d;
    logic              dq_full, dq_nonempty_d;

    logic              rd_fire;
    logic              pkt_avail_q;
    logic [15:0]       pkt_length_q;
    logic [ADDR_W-1:0] rem_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_last_q;

    // One slot is kept free so that wr_ptr == rd_ptr always means empty.
    function automatic logic is_full(input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] rd);
        logic [ADDR_W-1:0] diff;
        diff = base - rd;
        return &diff;
    endfunction

    assign dq_full = (dq_wr_q[PKT_W] != dq_rd_q[PKT_W]) &&
                     (dq_wr_q[PKT_W-1:0] == dq_rd_q[PKT_W-1:0]);

    // Write FSM: next state, pointer movement and commit/drop resolution.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        wcnt_d       = wcnt_q;
        bad_d        = bad_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q;
        push         = 1'b0;
        drop_abandon = 1'b0;
        drop_resolve = 1'b0;
        start        = 1'b0;
        eof_now      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && bus.in_sof) begin
                    start = 1'b1;
                end
            end
            StFill, StSkip: begin
                if (bus.in_valid) begin
                    if (bus.in_sof) begin
                        start        = 1'b1;
                        drop_abandon = 1'b1;
                    end else begin
                        if (state_q == StFill) begin
                            if (is_full(wr_ptr_q, rd_ptr_q)) begin
                                bad_d   = 1'b1;
                                state_d = StSkip;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                                wcnt_d   = wcnt_q + ADDR_W'(1);
                            end
                        end
                        eof_now = bus.in_eof;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new payload always starts at the commit boundary.
        if (start) begin
            mem_waddr = cm_ptr_q;
            if (is_full(cm_ptr_q, rd_ptr_q)) begin
                bad_d    = 1'b1;
                wcnt_d   = '0;
                wr_ptr_d = cm_ptr_q;
                state_d  = StSkip;
            end else begin
                bad_d    = 1'b0;
                mem_we   = 1'b1;
                wcnt_d   = ADDR_W'(1);
                wr_ptr_d = cm_ptr_q + ADDR_W'(1);
                state_d  = StFill;
            end
            eof_now = bus.in_eof;
        end

        if (eof_now) begin
            if (bus.in_good && !bad_d && !dq_full) begin
                cm_ptr_d = wr_ptr_d;
                push     = 1'b1;
            end else begin
                wr_ptr_d     = cm_ptr_q;
                drop_resolve = 1'b1;
            end
            bad_d   = 1'b0;
            state_d = StIdle;
        end
    end

    assign push_desc = {bus.in_length, wcnt_d};

    // Read side: a request is honoured only while a committed packet is presented.
    always_comb begin
        rd_fire       = pkt_avail_q && bus.rd_req;
        pop           = rd_fire && (rem_q == ADDR_W'(1));
        rd_ptr_d      = rd_ptr_q + ADDR_W'(rd_fire);
        dq_wr_d       = dq_wr_q + QptrW'(push);
        dq_rd_d       = dq_rd_q + QptrW'(pop);
        dq_nonempty_d = (dq_wr_d != dq_rd_d);
        // A descriptor pushed into an empty FIFO is not yet in desc_mem; bypass it.
        head_desc     = (dq_wr_q == dq_rd_q) ? push_desc : desc_mem[dq_rd_q[PKT_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.in_data;
        end
        if (push) begin
            desc_mem[dq_wr_q[PKT_W-1:0]] <= push_desc;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            wcnt_q   <= '0;
            bad_q    <= 1'b0;
            dq_wr_q  <= '0;
            dq_rd_q  <= '0;
            used_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wcnt_q   <= wcnt_d;
            bad_q    <= bad_d;
            dq_wr_q  <= dq_wr_d;
            dq_rd_q  <= dq_rd_d;
            used_q   <= {1'b0, wr_ptr_d - rd_ptr_d};
        end
    end

    // Head presentation drops for one cycle after each pop, then reloads the next descriptor.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pkt_avail_q  <= 1'b0;
            pkt_length_q <= '0;
            rem_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_last_q  <= pop;
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr_q];
            end
            if (pkt_avail_q) begin
                if (rd_fire) begin
                    rem_q <= rem_q - ADDR_W'(1);
                end
                if (pop) begin
                    pkt_avail_q  <= 1'b0;
                    pkt_length_q <= '0;
                end
            end else begin
                pkt_avail_q <= dq_nonempty_d;
                if (dq_nonempty_d) begin
                    pkt_length_q <= head_desc[DescW-1:ADDR_W];
                    rem_q        <= head_desc[ADDR_W-1:0];
                end
            end
        end
    end

    assign bus.pkt_avail  = pkt_avail_q;
    assign bus.pkt_length = pkt_length_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_last    = rd_last_q;
    assign bus.used_words = used_q;

`ifdef UDP_RXBUF_STATS_EN
    logic [15:0] drop_cnt_q;
    logic        ovf_q;
    logic [15:0] drop_n;

    // An SOF restart and a failing EOF in the same cycle are two separate drops.
    assign drop_n = {15'd0, drop_abandon} + {15'd0, drop_resolve};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= drop_abandon | drop_resolve;
            if (drop_n != 16'd0) begin
                drop_cnt_q <= (drop_cnt_q > (16'hFFFF - drop_n)) ? 16'hFFFF
                                                                 : drop_cnt_q + drop_n;
            end
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
    assign bus.ovf      = ovf_q;
`else
    logic unused_drop;
    assign unused_drop  = drop_abandon | drop_resolve;
    assign bus.drop_cnt = '0;
    assign bus.ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// tb_udp_rx_pkt_buffer: directed test of udp_rx_pkt_buffer with a 16-word buffer and
// a 4-entry descriptor FIFO; drop statistics expectations follow UDP_RXBUF_STATS_EN.
module tb_udp_rx_pkt_buffer;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 2;
`ifdef UDP_RXBUF_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic clk;
    logic clr;
    int   n_chk;
    int   n_bad;

    udp_rx_pkt_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    udp_rx_pkt_buffer #(.DATA_W(DW), .ADDR_W(AW), .PKT_W(PW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic in_idle();
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        bus.in_good   = 1'b0;
        bus.in_data   = '0;
        bus.in_length = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sof, input logic eof,
                             input logic good, input logic [15:0] len);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_sof    = sof;
        bus.in_eof    = eof;
        bus.in_good   = good;
        bus.in_length = len;
        tick();
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base, input logic good,
                            input logic [15:0] len);
        for (int i = 0; i < n; i++) begin
            send_word(base + i, i == 0, i == n - 1, good, len);
        end
        in_idle();
    endtask

    task automatic read_pkt(input int n, input logic [31:0] base, input logic [15:0] len);
        int waited;
        waited = 0;
        while (bus.pkt_avail !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("pkt_avail", {31'd0, bus.pkt_avail}, 32'd1);
        check("pkt_length", {16'd0, bus.pkt_length}, {16'd0, len});
        for (int i = 0; i < n; i++) begin
            bus.rd_req = 1'b1;
            tick();
            check("rd_valid", {31'd0, bus.rd_valid}, 32'd1);
            check("rd_data", bus.rd_data, base + i);
            check("rd_last", {31'd0, bus.rd_last}, (i == n - 1) ? 32'd1 : 32'd0);
        end
        bus.rd_req = 1'b0;
        check("avail_after_last", {31'd0, bus.pkt_avail}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_avail"}, {31'd0, bus.pkt_avail}, 32'd0);
        check({tag, "_length"}, {16'd0, bus.pkt_length}, 32'd0);
        check({tag, "_rd_data"}, bus.rd_data, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, bus.rd_valid}, 32'd0);
        check({tag, "_rd_last"}, {31'd0, bus.rd_last}, 32'd0);
        check({tag, "_used"}, {27'd0, bus.used_words}, 32'd0);
        check({tag, "_drop_cnt"}, {16'd0, bus.drop_cnt}, 32'd0);
        check({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        clr = 1'b0;
        bus.rd_req = 1'b0;
        in_idle();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        clr = 1'b1;
        tick();

        // Single good payload: 3 words, 12 bytes.
        send_word(32'hA000_0000, 1'b1, 1'b0, 1'b1, 16'd12);
        send_word(32'hA000_0001, 1'b0, 1'b0, 1'b1, 16'd12);
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hA000_0002;
        bus.in_eof    = 1'b1;
        bus.in_good   = 1'b1;
        bus.in_length = 16'd12;
        check("avail_before_commit", {31'd0, bus.pkt_avail}, 32'd0);
        tick();
        in_idle();
        check("avail_after_commit", {31'd0, bus.pkt_avail}, 32'd1);
        check("len_after_commit", {16'd0, bus.pkt_length}, 32'd12);
        check("used_after_commit", {27'd0, bus.used_words}, 32'd3);
        read_pkt(3, 32'hA000_0000, 16'd12);
        check("used_after_read", {27'd0, bus.used_words}, 32'd0);

        // Bad frame behind one good packet.
        send_pkt(2, 32'hB000_0000, 1'b1, 16'd8);
        send_pkt(5, 32'hBB00_0000, 1'b0, 16'd20);
        check("bad_ovf_pulse", {31'd0, bus.ovf}, {31'd0, Stats});
        check("bad_drop_cnt", {16'd0, bus.drop_cnt}, Stats ? 32'd1 : 32'd0);
        check("bad_used", {27'd0, bus.used_words}, 32'd2);
        tick();
        check("bad_ovf_single", {31'd0, bus.ovf}, 32'd0);
        read_pkt(2, 32'hB000_0000, 16'd8);

        // Overflow: 20 words into a 16-word buffer (15 usable).
        for (int i = 0; i < 20; i++) begin
            send_word(32'hC000_0000 + i, i == 0, i == 19, 1'b1, 16'd80);
            if (i == 14) check("ovf_used_15", {27'd0, bus.used_words}, 32'd15);
        end
        in_idle();
        check("ovf_pulse", {31'd0, bus.ovf}, {31'd0, Stats});
        check("ovf_drop_cnt", {16'd0, bus.drop_cnt}, Stats ? 32'd2 : 32'd0);
        check("ovf_used_0", {27'd0, bus.used_words}, 32'd0);
        check("ovf_no_avail", {31'd0, bus.pkt_avail}, 32'd0);
        send_pkt(2, 32'hC100_0000, 1'b1, 16'd7);
        read_pkt(2, 32'hC100_0000, 16'd7);

        // Descriptor FIFO full: 5 one-word packets, no reads.
        for (int k = 0; k < 5; k++) begin
            send_word(32'hD000_0000 + k, 1'b1, 1'b1, 1'b1, 16'(4 + k));
        end
        in_idle();
        check("dfull_drop_cnt", {16'd0, bus.drop_cnt}, Stats ? 32'd3 : 32'd0);
        check("dfull_used", {27'd0, bus.used_words}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            read_pkt(1, 32'hD000_0000 + k, 16'(4 + k));
        end
        check("dfull_used_after", {27'd0, bus.used_words}, 32'd0);

        // Pointer wrap: 8 x 7-word packets through a 16-word buffer.
        for (int it = 0; it < 8; it++) begin
            send_pkt(7, 32'hE000_0000 + it * 16, 1'b1, 16'd28);
            check("wrap_used", {27'd0, bus.used_words}, 32'd7);
            read_pkt(7, 32'hE000_0000 + it * 16, 16'd28);
        end

        // Reset mid-fill with 2 committed packets and a read in flight.
        send_pkt(2, 32'hF000_0000, 1'b1, 16'd8);
        send_pkt(2, 32'hF100_0000, 1'b1, 16'd6);
        bus.rd_req = 1'b1;
        send_word(32'hF200_0000, 1'b1, 1'b0, 1'b1, 16'd12);
        check("pre_reset_valid", {31'd0, bus.rd_valid}, 32'd1);
        check("pre_reset_data", bus.rd_data, 32'hF000_0000);
        #2 clr = 1'b0;
        #1;
        check_outputs_zero("midreset");
        bus.rd_req = 1'b0;
        in_idle();
        #2 clr = 1'b1;
        tick();
        send_pkt(3, 32'h1234_0000, 1'b1, 16'd11);
        check("post_reset_used", {27'd0, bus.used_words}, 32'd3);
        read_pkt(3, 32'h1234_0000, 16'd11);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
